pp_command_gen: RTL
===================

// Module: pp_command_gen
// PURPOSE
// User-command front end for the pixel-processor controller. Debounces the calibrate and clear
// push-buttons and runs a handshake that drives the controller's calibrate/clear inputs while
// watching its enable/calibrateEnable/error outputs. Holds calibrate for exactly CAL_FRAMES video
// frames. Sits between the board keys and the pixel-processor state machine.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  consecutive stable cycles before a key level is accepted (10 ms @ 50 MHz)
// CAL_FRAMES       16      frame_start pulses that calibrate is held after calibrateEnable is seen
// TIMEOUT_CYCLES   1024    max cycles to wait for any controller acknowledge before abandoning
// PORTS
// clk              in   1  system clock; single clock domain
// reset            in   1  asynchronous, active-low reset
// key_calibrate_n  in   1  raw calibrate button, active-low, asynchronous to clk
// key_clear_n      in   1  raw clear button, active-low, asynchronous to clk
// frame_start      in   1  one-cycle pulse at start of each video frame
// enable           in   1  controller status: processing enabled
// calibrateEnable  in   1  controller status: calibrating
// error            in   1  controller status: in reset/clear state
// calibrate        out  1  level to controller; high = request calibration
// clear            out  1  level to controller; high = request clear
// busy             out  1  high whenever FSM is not IDLE
// timeout          out  1  one-cycle pulse when an acknowledge wait expires
// BEHAVIOUR
// Reset: all outputs 0, FSM IDLE, debounced keys = released, all counters 0, clr_pending 0.
// Key path (each key): 2-flop synchronizer -> counter; debounced level updates only after the
//   synced level differs from it for DEBOUNCE_CYCLES consecutive cycles (any bounce restarts count).
//   Press event = 1-cycle pulse on debounced released->pressed. Release generates no event.
// FSM (all outputs registered, change the cycle after the transition condition):
//   IDLE:     cal press & enable=0 & calibrateEnable=0 & error=0 -> CAL_WAIT (calibrate<=1).
//             clear press & enable=1 -> CLR_WAIT (clear<=1). Other presses ignored (no pending).
//   CAL_WAIT: calibrateEnable=1 -> CAL_RUN, frame count cleared. Timeout -> IDLE, calibrate<=0.
//   CAL_RUN:  count frame_start pulses from the cycle after entry; on the CAL_FRAMES-th pulse
//             calibrate<=0 -> CAL_DONE.
//   CAL_DONE: enable=1 -> CLR_WAIT (clear<=1) if clr_pending, else IDLE. Timeout -> IDLE.
//   CLR_WAIT: error=1 -> CLR_REL (clear<=0). Timeout -> IDLE, clear<=0.
//   CLR_REL:  error=0 -> IDLE. Timeout -> IDLE.
// Clear press in CAL_WAIT/CAL_RUN: sets clr_pending, calibrate<=0 next cycle, go CAL_DONE
//   (CAL_WAIT abort goes to IDLE if calibrateEnable never rose; clr_pending dropped).
// Simultaneous cal and clear press in IDLE: clear wins if enable=1, else calibrate path.
// Clear press in CLR_* ignored. clr_pending cleared on entering CLR_WAIT or IDLE.
// Timeout: per-state cycle counter, reset on every state change; expiry after TIMEOUT_CYCLES
//   cycles in the state -> 1-cycle timeout pulse, same cycle as return to IDLE decision.
// calibrate and clear are never high in the same cycle. Counters saturate, never wrap.
// Reset asserted mid-operation: outputs drop to 0 immediately (async), FSM to IDLE.
// Latency: raw press to calibrate high = 2 + DEBOUNCE_CYCLES + 2 cycles.
// TESTING (bench params DEBOUNCE_CYCLES=4, CAL_FRAMES=3, TIMEOUT_CYCLES=32)
// 1 Clean cal press, model controller acks calibrateEnable after 2 cycles -> calibrate high until
//   cycle after 3rd frame_start, then low; enable=1 -> busy low; no timeout pulse.
// 2 Bouncy key (toggle every 2 cycles for 20 cycles, then hold low) -> exactly one press event,
//   calibrate rises 8 cycles after final stable low.
// 3 enable=1, clear press, error rises 3 cycles later -> clear high 3 cycles, error falls -> IDLE.
// 4 Clear press during CAL_RUN after 1 frame -> calibrate low next cycle; on enable=1 clear
//   asserts; calibrate and clear never simultaneously high.
// 5 Cal press, controller never acks -> calibrate high 32 cycles, timeout pulse, IDLE.
// 6 Reset low during CLR_WAIT -> clear, busy 0 without clk edge; cal press while enable=1 ignored.

Source files
------------

// File: rtl/pp_command_gen.sv
// Pixel-processor command front end: debounced calibrate/clear keys drive a
// handshake FSM toward the controller (calibrate/clear out, status in).
//
// Ports: clk, reset (async, active low), key_calibrate_n, key_clear_n,
//        frame_start, enable, calibrateEnable, error -> calibrate, clear,
//        busy, timeout.

module pp_key_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic s1;
  logic s2;
  logic deb;
  logic deb_d;
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      deb_d <= deb;
      // registered edge detect adds the final stage of key latency
      press <= deb_d & ~deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module pp_command_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CAL_FRAMES      = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic key_calibrate_n,
  input  logic key_clear_n,
  input  logic frame_start,
  input  logic enable,
  input  logic calibrateEnable,
  input  logic error,
  output logic calibrate,
  output logic clear,
  output logic busy,
  output logic timeout
);

  localparam int FW = (CAL_FRAMES > 1) ? $clog2(CAL_FRAMES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(CAL_FRAMES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CAL_WAIT, CAL_RUN, CAL_DONE, CLR_WAIT, CLR_REL
  } state_t;

  state_t state, state_n;

  logic cal_press;
  logic clr_press;
  logic clr_pending, pend_n;
  logic cal_n, clr_n, tmo_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [TW-1:0] tcnt;
  logic expired;

  pp_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_cal (
    .clk   (clk),
    .reset (reset),
    .key_n (key_calibrate_n),
    .press (cal_press)
  );

  pp_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk),
    .reset (reset),
    .key_n (key_clear_n),
    .press (clr_press)
  );

  assign expired = (tcnt == TLAST);

  always_comb begin
    state_n = state;
    cal_n   = calibrate;
    clr_n   = clear;
    pend_n  = clr_pending;
    fcnt_n  = fcnt;
    tmo_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_press && enable) begin
          state_n = CLR_WAIT;
          clr_n   = 1'b1;
        end else if (cal_press && !enable &&
                     !calibrateEnable && !error) begin
          state_n = CAL_WAIT;
          cal_n   = 1'b1;
        end
      end
      CAL_WAIT: begin
        if (clr_press) begin
          cal_n = 1'b0;
          // only defer the clear if calibration actually started
          if (calibrateEnable) begin
            state_n = CAL_DONE;
            pend_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (calibrateEnable) begin
          state_n = CAL_RUN;
          fcnt_n  = '0;
        end else if (expired) begin
          state_n = IDLE;
          cal_n   = 1'b0;
          tmo_n   = 1'b1;
        end
      end
      CAL_RUN: begin
        if (clr_press) begin
          state_n = CAL_DONE;
          cal_n   = 1'b0;
          pend_n  = 1'b1;
        end else if (frame_start) begin
          if (fcnt == FLAST) begin
            state_n = CAL_DONE;
            cal_n   = 1'b0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      CAL_DONE: begin
        if (enable) begin
          if (clr_pending) begin
            state_n = CLR_WAIT;
            clr_n   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (expired) begin
          state_n = IDLE;
          tmo_n   = 1'b1;
        end
      end
      CLR_WAIT: begin
        if (error) begin
          state_n = CLR_REL;
          clr_n   = 1'b0;
        end else if (expired) begin
          state_n = IDLE;
          clr_n   = 1'b0;
          tmo_n   = 1'b1;
        end
      end
      CLR_REL: begin
        if (!error) begin
          state_n = IDLE;
        end else if (expired) begin
          state_n = IDLE;
          tmo_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE || state_n == CLR_WAIT) begin
      pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      calibrate   <= 1'b0;
      clear       <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      clr_pending <= 1'b0;
      fcnt        <= '0;
      tcnt        <= '0;
    end else begin
      state       <= state_n;
      calibrate   <= cal_n;
      clear       <= clr_n;
      busy        <= (state_n != IDLE);
      timeout     <= tmo_n;
      clr_pending <= pend_n;
      fcnt        <= fcnt_n;
      if (state_n != state) begin
        tcnt <= '0;
      end else if (tcnt != TLAST) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule
